// File: rtl/tb_constants.sv
// Shared constants for the RV32 core environment: NOP encoding, memory
// responder FSM states and default end-of-program / result-check values.
package tb_constants;

    localparam logic [31:0] RV32_NOP            = 32'h0000_0013;

    localparam logic [31:0] DEF_SIM_STOP_PC     = 32'h0000_0018;
    localparam logic [31:0] DEF_MEM_CHECK_ADDR  = 32'h0000_0040;
    localparam logic [31:0] DEF_EXPECTED_RESULT = 32'h0000_003F;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } mem_state_t;

endpackage

// File: rtl/rv32_mem_delay.sv
// Fixed-depth shift register with asynchronous active-low clear; every stage
// resets to RESET_VAL so the output holds that value until real data arrives.
module rv32_mem_delay #(
    parameter int unsigned       DEPTH     = 1,
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= RESET_VAL;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/rv32_mem_responder.sv
// Shared instruction/data memory for the RV32 core: preload during reset,
// read-first pipelined reads, sticky address-error flags, end-of-program check.
module rv32_mem_responder
    import tb_constants::*;
#(
    parameter int unsigned MEM_WORDS       = 32,
    parameter int unsigned READ_LATENCY    = 1,
    parameter logic [31:0] SIM_STOP_PC     = DEF_SIM_STOP_PC,
    parameter logic [31:0] MEM_CHECK_ADDR  = DEF_MEM_CHECK_ADDR,
    parameter logic [31:0] EXPECTED_RESULT = DEF_EXPECTED_RESULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_data_o,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i,
    output logic        instr_err_o,
    output logic        data_err_o,
    output logic        done_o,
    output logic        pass_o
);

    localparam int unsigned      IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0]      MEM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [IDX_W-1:0] CHECK_IDX = IDX_W'(MEM_CHECK_ADDR >> 2);

    logic [31:0] mem [MEM_WORDS];

    logic             instr_bad_c, data_bad_c, load_bad_c;
    logic [IDX_W-1:0] instr_idx_c, data_idx_c, load_idx_c;
    logic [31:0]      instr_rd_c, data_rd_c;
    logic             check_en_c;

    mem_state_t state_q, state_d;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= MEM_BYTES);
    endfunction

    // Address decode for all three ports
    always_comb begin
        instr_bad_c = addr_bad(instr_addr_i);
        data_bad_c  = addr_bad(mem_addr_i);
        load_bad_c  = addr_bad(load_addr_i);
        instr_idx_c = IDX_W'(instr_addr_i[31:2]);
        data_idx_c  = IDX_W'(mem_addr_i[31:2]);
        load_idx_c  = IDX_W'(load_addr_i[31:2]);
    end

    // Reads see the array before this edge's store, giving read-first behaviour
    always_comb begin
        instr_rd_c = instr_bad_c ? RV32_NOP : mem[instr_idx_c];
        data_rd_c  = data_bad_c  ? 32'h0    : mem[data_idx_c];
    end

    // Array is not reset; preload owns the write port while reset is held
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (load_we_i && !load_bad_c) begin
                mem[load_idx_c] <= load_data_i;
            end
        end else if (mem_we_i && !data_bad_c) begin
            mem[data_idx_c] <= mem_data_i;
        end
    end

    rv32_mem_delay #(
        .DEPTH     (READ_LATENCY),
        .WIDTH     (32),
        .RESET_VAL (RV32_NOP)
    ) u_instr_delay (
        .clk   (clk_i),
        .rst_n (rst_i),
        .din   (instr_rd_c),
        .dout  (instr_data_o)
    );

    rv32_mem_delay #(
        .DEPTH     (READ_LATENCY),
        .WIDTH     (32),
        .RESET_VAL (32'h0)
    ) u_data_delay (
        .clk   (clk_i),
        .rst_n (rst_i),
        .din   (data_rd_c),
        .dout  (mem_data_o)
    );

    // Sticky error flags, independent of read latency
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            instr_err_o <= 1'b0;
            data_err_o  <= 1'b0;
        end else begin
            if (instr_bad_c) instr_err_o <= 1'b1;
            if (data_bad_c)  data_err_o  <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (instr_addr_i == SIM_STOP_PC) state_d = CHECK;
            CHECK:   state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        check_en_c = 1'b0;
        if (state_q == CHECK) check_en_c = 1'b1;
    end

    // Result is captured once; later stores to the check word do not change it
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            done_o <= 1'b0;
            pass_o <= 1'b0;
        end else if (check_en_c) begin
            done_o <= 1'b1;
            pass_o <= (mem[CHECK_IDX] == EXPECTED_RESULT);
        end
    end

endmodule

// File: doc/rv32_mem_responder.md
# rv32_mem_responder

Synthesizable memory responder for the RV32 core's instruction and data buses. It serves instruction fetches and data loads/stores from one shared word array, with a configurable read latency. During reset it accepts a preload write port, and it flags bad addresses. It also detects end-of-program and checks a result word, replacing the behavioural memory tasks in the core testbench.

## Interface
- MEM_WORDS, 32 — array depth in 32-bit words; valid byte addresses 0 .. MEM_WORDS*4-1
- READ_LATENCY, 1 — cycles from address to read data, legal 1..4, same for both ports
- SIM_STOP_PC, 32'h18 — fetch address that ends the program
- MEM_CHECK_ADDR, 32'h40 — byte address of the result word
- EXPECTED_RESULT, 32'h3F — required value at MEM_CHECK_ADDR
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- instr_addr_i  in  32  fetch byte address from core
- instr_data_o  out  32  fetched instruction
- mem_we_i  in  1  store enable from core
- mem_addr_i  in  32  data byte address from core
- mem_data_i  in  32  store data from core
- mem_data_o  out  32  load data to core
- load_we_i  in  1  preload write enable, honoured only while rst_i=0
- load_addr_i  in  32  preload byte address
- load_data_i  in  32  preload data
- instr_err_o  out  1  sticky: bad fetch address seen
- data_err_o  out  1  sticky: bad data address seen
- done_o  out  1  sticky: SIM_STOP_PC reached and check complete
- pass_o  out  1  valid when done_o=1; result matched

## Operation
- Word index is addr[31:2]. An address is bad if addr[1:0]!=0 or addr >= MEM_WORDS*4.
- Array contents are not reset. Registers are.
- Preload: while rst_i=0, load_we_i=1 with a good load_addr_i writes load_data_i on the clock edge. Bad preload addresses are ignored silently. Core ports are ignored during reset.
- Fetch: a good address reads array[idx]. A bad address returns RV32_NOP (32'h0000_0013) and sets instr_err_o.
- Load: a good address reads array[idx]. A bad address returns 0 and sets data_err_o.
- Store: mem_we_i=1 with a good address writes mem_data_i at the edge. A bad address suppresses the write and sets data_err_o.
- Reads are read-first. A same-cycle store to the word being read, on either port, returns the old value.
- FSM mem_state_t:
  - RUN: go to CHECK on the first cycle out of reset where instr_addr_i==SIM_STOP_PC.
  - CHECK: exactly one cycle. Compares array[MEM_CHECK_ADDR/4], which includes a store committed on the RUN→CHECK edge. Loads pass_o, sets done_o, then goes to DONE.
  - DONE: absorbing. Memory keeps serving the core.
- Stores in DONE still write. pass_o does not re-evaluate.

## Timing
- Reset values:
  - instr_data_o = 32'h0000_0013
  - mem_data_o = 0
  - instr_err_o = 0, data_err_o = 0
  - done_o = 0, pass_o = 0
  - FSM = RUN
  - every latency stage holds its output's reset value
- Read data for an address presented at edge N appears after edge N+READ_LATENCY and is held until replaced. Back-to-back reads are fully pipelined, one per cycle.
- Error flags set on the edge after the bad address is sampled, independent of READ_LATENCY.
- done_o rises 2 edges after the cycle in which instr_addr_i first equals SIM_STOP_PC.
- rst_i asserted mid-operation: registers, pipeline and FSM clear immediately. In-flight reads are discarded. The array is retained, so a program can be re-run without preload.

## Structure
- Add to the existing shared constants package (tb_constants):
  - RV32_NOP
  - mem_state_t enum {RUN, CHECK, DONE}
  - default values for SIM_STOP_PC / MEM_CHECK_ADDR / EXPECTED_RESULT
- Sub-module rv32_mem_delay, parameterized DEPTH/WIDTH/RESET_VAL, async active-low clear shift register. Instantiate it twice, once for the instruction read path and once for the data read path.
- Top level holds: the array, address decode, error flags, the FSM.

## Test plan
- Basic program, READ_LATENCY=1:
  - preload lw/addi/addi/andi/sw/nop at words 0–5 and 3 at word 16
  - release reset and drive the core
  - required: word 16 = 32'h3F, done_o=1, pass_o=1, both err flags 0
- Same program with word 16 preloaded to 4 → done_o=1, pass_o=0.
- READ_LATENCY=3, fetch 0,4,8 on consecutive cycles → data for each appears exactly 3 edges after its address, in order.
- Read-first: load word 2 while storing 32'hDEAD_BEEF to word 2 in the same cycle → returns the old value. The next read returns 32'hDEAD_BEEF.
- Bad addresses:
  - fetch 32'h80 → instr_data_o = 32'h13, instr_err_o=1
  - store to 32'h41 → no write, data_err_o=1
  - both flags stay set
- Assert rst_i mid-program → outputs return to their reset values within the same cycle. Preload is intact. After release, re-running the program gives pass_o=1.
